// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer for the 16-bit single-issue pipeline.
// Owns the fetch PC and drives the variable-latency instruction-memory
// handshake. It applies execute-stage redirects and presents fetched
// instructions at the IF/ID boundary, with a one-entry skid buffer that
// absorbs a read completing while decode is stalled.
//
// Optional feature macro: PC_ALIGN_CHK_EN
//   defined   : an odd redirect target sets sticky err and halts fetch
//   undefined : redirect target bit 0 is forced to 0, err tied low
module fetch_seq #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               INC      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_pc,
  input  logic             stall,
  input  logic             halt,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_done,
  input  logic [WIDTH-1:0] imem_data,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc_next,
  output logic             halted,
  output logic             err
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_SKID,
    S_DRAIN,
    S_HALTED
  } state_t;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_t           state;
  logic [WIDTH-1:0] pc;            // address of the current / next request
  logic [WIDTH-1:0] pend_pc;       // target to resume at once a drain ends
  logic             drain_halt;    // drain ends in HALTED instead of FETCH
  logic [WIDTH-1:0] skid_instr;
  logic [WIDTH-1:0] skid_pc_next;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] redir_tgt;
  logic             redir_bad;
  logic             stop;
  logic             out_free;
  logic [WIDTH-1:0] drain_tgt;
  logic             drain_stop;

`ifdef PC_ALIGN_CHK_EN
  assign redir_tgt = redir_pc;
  assign redir_bad = redir_pc[0];
`else
  assign redir_tgt = redir_pc & ~WIDTH'(1);
  assign redir_bad = 1'b0;
`endif

  // Wraps modulo 2^WIDTH naturally.
  assign pc_inc   = pc + INC_W;
  // A redirect beats halt; a misaligned redirect behaves like halt.
  assign stop     = redir_valid ? redir_bad : halt;
  assign out_free = !if_valid || !stall;

  // While draining, the latest redirect replaces the pending target.
  assign drain_tgt  = (redir_valid && !redir_bad) ? redir_tgt : pend_pc;
  assign drain_stop = redir_valid ? redir_bad : (drain_halt || halt);

  // The request is a pure decode of the state register, so an async reset
  // drops it immediately; the address is held in pc until the read completes.
  assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
  assign imem_addr = pc;

  // Fetch FSM with registered IF/ID outputs and skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the skid data registers are reset along with the rest; they are
      // a single entry, so clearing them is cheap and keeps reset state clean.
      state        <= S_START;
      pc           <= RESET_PC;
      pend_pc      <= RESET_PC;
      drain_halt   <= 1'b0;
      skid_instr   <= '0;
      skid_pc_next <= '0;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc_next   <= '0;
      halted       <= 1'b0;
    end else begin
      // NOTE: every state register uses non-blocking assignment so all of
      // them update from the same pre-edge values regardless of order here.
      unique case (state)
        S_START: begin
          state <= S_FETCH;
        end

        S_FETCH: begin
          if (redir_valid || halt) begin
            if_valid <= 1'b0;
            if (imem_done) begin
              // Read completed this cycle: its data is discarded.
              if (stop) begin
                state  <= S_HALTED;
                halted <= 1'b1;
              end else begin
                pc <= redir_tgt;
              end
            end else begin
              state      <= S_DRAIN;
              pend_pc    <= redir_tgt;
              drain_halt <= stop;
            end
          end else if (imem_done) begin
            pc <= pc_inc;
            if (out_free) begin
              if_valid   <= 1'b1;
              if_instr   <= imem_data;
              if_pc_next <= pc_inc;
            end else begin
              skid_instr   <= imem_data;
              skid_pc_next <= pc_inc;
              state        <= S_SKID;
            end
          end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
          end
        end

        S_SKID: begin
          if (redir_valid || halt) begin
            if_valid <= 1'b0;
            if (stop) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              pc    <= redir_tgt;
              state <= S_FETCH;
            end
          end else if (!stall) begin
            if_valid   <= 1'b1;
            if_instr   <= skid_instr;
            if_pc_next <= skid_pc_next;
            state      <= S_FETCH;
          end
        end

        S_DRAIN: begin
          if (imem_done) begin
            if (drain_stop) begin
              state    <= S_HALTED;
              halted   <= 1'b1;
              if_valid <= 1'b0;
            end else begin
              pc    <= drain_tgt;
              state <= S_FETCH;
            end
          end else begin
            pend_pc    <= drain_tgt;
            drain_halt <= drain_stop;
          end
        end

        S_HALTED: begin
          // Only reset leaves HALTED.
        end

        default: begin
          state <= S_START;
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHK_EN
  // Sticky misalignment flag, raised by any odd redirect while fetching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (redir_valid && redir_bad &&
                 (state == S_FETCH || state == S_SKID || state == S_DRAIN)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed bench for fetch_seq. The memory model returns
// 16'hA000 | (addr >> 1) for every address.
module tb_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        stall;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_next;
  logic        halted;
  logic        err;

  int n_total = 0;
  int n_fail  = 0;

  fetch_seq #(
    .WIDTH   (16),
    .RESET_PC(16'h0000),
    .INC     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .stall      (stall),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_done  (imem_done),
    .imem_data  (imem_data),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc_next (if_pc_next),
    .halted     (halted),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read data; completion is driven by the stimulus.
  assign imem_data = 16'hA000 | (imem_addr >> 1);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 16'h0000;
    stall       = 1'b0;
    halt        = 1'b0;
    imem_done   = 1'b0;

    // Reset state
    #12;
    check("rst_req",      {15'd0, imem_req},  16'h0000);
    check("rst_addr",     imem_addr,          16'h0000);
    check("rst_valid",    {15'd0, if_valid},  16'h0000);
    check("rst_instr",    if_instr,           16'h0000);
    check("rst_pc_next",  if_pc_next,         16'h0000);
    check("rst_halted",   {15'd0, halted},    16'h0000);
    check("rst_err",      {15'd0, err},       16'h0000);

    // Reset release, zero-wait memory
    imem_done = 1'b1;
    rst_n     = 1'b1;
    tick();  // START -> FETCH
    check("first_req",  {15'd0, imem_req}, 16'h0001);
    check("first_addr", imem_addr,         16'h0000);
    check("first_valid",{15'd0, if_valid}, 16'h0000);
    tick();
    check("f0_instr",   if_instr,   16'hA000);
    check("f0_pc_next", if_pc_next, 16'h0002);
    check("f0_valid",   {15'd0, if_valid}, 16'h0001);
    check("f1_addr",    imem_addr,  16'h0002);
    tick();
    check("f1_instr",   if_instr,   16'hA001);
    check("f1_pc_next", if_pc_next, 16'h0004);
    check("f2_addr",    imem_addr,  16'h0004);
    tick();
    check("f2_instr",   if_instr,   16'hA002);
    check("f2_pc_next", if_pc_next, 16'h0006);
    check("f3_addr",    imem_addr,  16'h0006);

    // Stall for 3 cycles: the read at 0006 lands in the skid entry
    stall = 1'b1;
    tick();
    check("skid_req0",  {15'd0, imem_req}, 16'h0000);
    check("skid_hold0", if_instr,          16'hA002);
    check("skid_vld0",  {15'd0, if_valid}, 16'h0001);
    tick();
    check("skid_req1",  {15'd0, imem_req}, 16'h0000);
    check("skid_hold1", if_instr,          16'hA002);
    tick();
    check("skid_req2",  {15'd0, imem_req}, 16'h0000);
    check("skid_pcn2",  if_pc_next,        16'h0006);
    stall = 1'b0;
    tick();
    check("unskid_instr", if_instr,          16'hA003);
    check("unskid_pcn",   if_pc_next,        16'h0008);
    check("unskid_req",   {15'd0, imem_req}, 16'h0001);
    check("unskid_addr",  imem_addr,         16'h0008);
    tick();
    check("post_skid_instr", if_instr,   16'hA004);
    check("post_skid_pcn",   if_pc_next, 16'h000A);

    // Redirect to 0008 (read at 000A completes and is discarded)
    redir_valid = 1'b1;
    redir_pc    = 16'h0008;
    tick();
    check("rd8_addr",  imem_addr,         16'h0008);
    check("rd8_valid", {15'd0, if_valid}, 16'h0000);

    // 3-cycle memory, redirect to 0040 in cycle 1 of the request at 0008
    imem_done   = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 16'h0040;
    tick();
    redir_valid = 1'b0;
    check("drain_req1",  {15'd0, imem_req}, 16'h0001);
    check("drain_addr1", imem_addr,         16'h0008);
    check("drain_vld1",  {15'd0, if_valid}, 16'h0000);
    tick();
    check("drain_addr2", imem_addr,         16'h0008);
    check("drain_vld2",  {15'd0, if_valid}, 16'h0000);
    imem_done = 1'b1;
    tick();
    check("redir_req",   {15'd0, imem_req}, 16'h0001);
    check("redir_addr",  imem_addr,         16'h0040);
    check("redir_vld",   {15'd0, if_valid}, 16'h0000);
    tick();
    check("redir_instr", if_instr,   16'hA020);
    check("redir_pcn",   if_pc_next, 16'h0042);

    // Redirect and halt together: redirect wins
    redir_valid = 1'b1;
    redir_pc    = 16'h0100;
    halt        = 1'b1;
    tick();
    redir_valid = 1'b0;
    halt        = 1'b0;
    check("rh_halted", {15'd0, halted}, 16'h0000);
    check("rh_addr",   imem_addr,       16'h0100);
    tick();
    check("rh_instr",  if_instr,   16'hA080);
    check("rh_pcn",    if_pc_next, 16'h0102);

    // Halt pulse with zero-wait memory
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_halted", {15'd0, halted},   16'h0001);
    check("halt_req",    {15'd0, imem_req}, 16'h0000);
    check("halt_valid",  {15'd0, if_valid}, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      redir_valid = i[0];
      redir_pc    = 16'h0200;
      tick();
      check("halted_req",  {15'd0, imem_req}, 16'h0000);
      check("halted_flag", {15'd0, halted},   16'h0001);
    end
    redir_valid = 1'b0;

    // Asynchronous reset out of HALTED
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_halted", {15'd0, halted},   16'h0000);
    check("areset_req",    {15'd0, imem_req}, 16'h0000);
    rst_n = 1'b1;
    tick();
    check("restart_req",  {15'd0, imem_req}, 16'h0001);
    check("restart_addr", imem_addr,         16'h0000);

    // Reset in the middle of a request drops it immediately
    #2;
    rst_n = 1'b0;
    #1;
    check("midreq_req", {15'd0, imem_req}, 16'h0000);
    rst_n = 1'b1;
    tick();
    check("midreq_restart", imem_addr, 16'h0000);

    // PC wrap: 16'hFFFE + 2 = 16'h0000
    redir_valid = 1'b1;
    redir_pc    = 16'hFFFE;
    tick();
    redir_valid = 1'b0;
    check("wrap_addr0", imem_addr, 16'hFFFE);
    tick();
    check("wrap_instr", if_instr,   16'hFFFF);
    check("wrap_pcn",   if_pc_next, 16'h0000);
    check("wrap_addr1", imem_addr,  16'h0000);

    // Misaligned redirect
    redir_valid = 1'b1;
    redir_pc    = 16'h0013;
    tick();
    redir_valid = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    check("align_err",    {15'd0, err},      16'h0001);
    check("align_halted", {15'd0, halted},   16'h0001);
    check("align_req",    {15'd0, imem_req}, 16'h0000);
    tick();
    check("align_err_sticky", {15'd0, err}, 16'h0001);
`else
    check("align_addr",   imem_addr,         16'h0012);
    check("align_err",    {15'd0, err},      16'h0000);
    check("align_halted", {15'd0, halted},   16'h0000);
    tick();
    check("align_instr",  if_instr,   16'hA009);
    check("align_pcn",    if_pc_next, 16'h0014);
`endif

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
